uart_bus_master: RTL and testbench



---
 rtl/uart_bus_master_if.sv | 24 ++
 rtl/uart_bus_master.sv | 153 +++++++++++++++
 tb/tb_uart_bus_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - UART byte stream and peripheral bus signals of the debug bridge
interface uart_bus_master_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;

   modport master (
      input  rx_data, rx_valid, tx_busy, rdata,
      output tx_data, tx_start, rd, wr, addr, wdata, busy
   );

   modport slave (
      output rx_data, rx_valid, tx_busy, rdata,
      input  tx_data, tx_start, rd, wr, addr, wdata, busy
   );
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command-frame parser acting as peripheral bus initiator
// Define UART_BUS_CHECKSUM_EN for a trailing XOR byte on frames and read responses.
module uart_bus_master #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 20
) (
   input logic               clk,
   input logic               reset,
   uart_bus_master_if.master bus
);
`ifdef UART_BUS_CHECKSUM_EN
   localparam int RESP_W = 40;
`else
   localparam int RESP_W = 32;
`endif
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] ACK     = 8'h4B;
   localparam logic [7:0] NAK     = 8'h3F;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, GET_ADDR, GET_DATA,
`ifdef UART_BUS_CHECKSUM_EN
      GET_SUM,
`endif
      BUS_RD, BUS_WR, SEND, SEND_WAIT
   } state_t;

   state_t            state, state_next;
   logic              is_write, wait_first;
   logic [1:0]        byte_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [RESP_W-1:0] resp;
   logic [2:0]        resp_left;
   logic              cmd_ok, last_byte, timed_out, in_frame;
`ifdef UART_BUS_CHECKSUM_EN
   localparam logic [7:0] SUM_ERR = 8'h21;
   logic [7:0]        sum;
   logic              sum_ok;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_ok     = (bus.rx_data == CMD_RD) || (bus.rx_data == CMD_WR);
      last_byte  = bus.rx_valid && (byte_cnt == 2'd3);
      timed_out  = !bus.rx_valid && (to_cnt == TO_LAST);
      in_frame   = (state == GET_ADDR) || (state == GET_DATA);
`ifdef UART_BUS_CHECKSUM_EN
      sum_ok     = (bus.rx_data == sum);
      in_frame   = in_frame || (state == GET_SUM);
`endif
      case (state)
         IDLE:      if (bus.rx_valid) state_next = cmd_ok ? GET_ADDR : SEND;
`ifdef UART_BUS_CHECKSUM_EN
         GET_ADDR:  if (timed_out) state_next = IDLE;
                    else if (last_byte) state_next = is_write ? GET_DATA : GET_SUM;
         GET_DATA:  if (timed_out) state_next = IDLE;
                    else if (last_byte) state_next = GET_SUM;
         GET_SUM:   if (timed_out) state_next = IDLE;
                    else if (bus.rx_valid) state_next = !sum_ok ? SEND : (is_write ? BUS_WR : BUS_RD);
`else
         GET_ADDR:  if (timed_out) state_next = IDLE;
                    else if (last_byte) state_next = is_write ? GET_DATA : BUS_RD;
         GET_DATA:  if (timed_out) state_next = IDLE;
                    else if (last_byte) state_next = BUS_WR;
`endif
         BUS_RD:    state_next = SEND;
         BUS_WR:    state_next = SEND;
         SEND:      if (!bus.tx_busy) state_next = SEND_WAIT;
         // the transmitter raises tx_busy one cycle after tx_start, so skip that cycle
         SEND_WAIT: if (!wait_first && !bus.tx_busy) state_next = (resp_left != 3'd0) ? SEND : IDLE;
         default:   state_next = IDLE;
      endcase
      bus.rd       = (state == BUS_RD);
      bus.wr       = (state == BUS_WR);
      bus.tx_start = (state == SEND) && !bus.tx_busy;
      bus.tx_data  = resp[RESP_W-1 -: 8];
      bus.busy     = (state != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         is_write   <= 1'b0;
         wait_first <= 1'b0;
         byte_cnt   <= 2'd0;
         to_cnt     <= '0;
         resp       <= '0;
         resp_left  <= 3'd0;
         bus.addr   <= 32'd0;
         bus.wdata  <= 32'd0;
`ifdef UART_BUS_CHECKSUM_EN
         sum        <= 8'd0;
`endif
      end else if (in_frame) begin
         if (bus.rx_valid) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == GET_ADDR) bus.addr  <= {bus.addr[23:0], bus.rx_data};
            if (state == GET_DATA) bus.wdata <= {bus.wdata[23:0], bus.rx_data};
`ifdef UART_BUS_CHECKSUM_EN
            sum <= sum ^ bus.rx_data;
            if (state == GET_SUM && !sum_ok) begin
               resp      <= {SUM_ERR, {(RESP_W-8){1'b0}}};
               resp_left <= 3'd1;
            end
`endif
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end else begin
         case (state)
            IDLE: if (bus.rx_valid) begin
               if (cmd_ok) begin
                  is_write <= (bus.rx_data == CMD_WR);
                  byte_cnt <= 2'd0;
                  to_cnt   <= '0;
`ifdef UART_BUS_CHECKSUM_EN
                  sum      <= bus.rx_data;
`endif
               end else begin
                  resp      <= {NAK, {(RESP_W-8){1'b0}}};
                  resp_left <= 3'd1;
               end
            end
            BUS_RD: begin
`ifdef UART_BUS_CHECKSUM_EN
               resp <= {bus.rdata, bus.rdata[31:24] ^ bus.rdata[23:16] ^ bus.rdata[15:8] ^ bus.rdata[7:0]};
`else
               resp <= bus.rdata;
`endif
               resp_left <= 3'(RESP_W / 8);
            end
            BUS_WR: begin
               resp      <= {ACK, {(RESP_W-8){1'b0}}};
               resp_left <= 3'd1;
            end
            SEND: if (!bus.tx_busy) begin
               resp       <= resp << 8;
               resp_left  <= resp_left - 3'd1;
               wait_first <= 1'b1;
            end
            SEND_WAIT: wait_first <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - randomized self-checking bench for uart_bus_master
module tb_uart_bus_master;
   localparam int TO = 100;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] rd_value = 32'h0;
   int hold_max = 4;

   logic [7:0]  tx_q[$];
   logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
   int bad_start = 0, overlap = 0;

   uart_bus_master_if bus_if();

   uart_bus_master #(.TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   // bus responder: read data is presented combinationally while rd is high
   assign bus_if.rdata = bus_if.rd ? rd_value : 32'h0;

   always @(negedge clk) begin
      if (bus_if.rd && bus_if.wr) overlap++;
      if (bus_if.wr) begin
         wr_addr_q.push_back(bus_if.addr);
         wr_data_q.push_back(bus_if.wdata);
      end
      if (bus_if.rd) rd_addr_q.push_back(bus_if.addr);
      if (bus_if.tx_start) begin
         if (bus_if.tx_busy) bad_start++;
         tx_q.push_back(bus_if.tx_data);
      end
   end

   // transmitter: busy from the cycle after tx_start for a random number of cycles
   initial begin
      bus_if.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.tx_start && reset) begin
            @(posedge clk);
            #1 bus_if.tx_busy = 1'b1;
            repeat ($urandom_range(1, hold_max)) @(posedge clk);
            #1 bus_if.tx_busy = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus_if.rx_data  = b;
      bus_if.rx_valid = 1'b1;
      tick(1);
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic clear_obs();
      tx_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      bad_start = 0;
      overlap = 0;
   endtask

   function automatic logic [7:0] pick_unknown();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
      return b;
   endfunction

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input int max_gap);
      logic [7:0] fr[$];
      logic [7:0] s;
      fr = {cmd};
      if (cmd == 8'h52 || cmd == 8'h57) begin
         fr = {fr, a[31:24], a[23:16], a[15:8], a[7:0]};
         if (cmd == 8'h57) fr = {fr, d[31:24], d[23:16], d[15:8], d[7:0]};
`ifdef UART_BUS_CHECKSUM_EN
         s = 8'h00;
         foreach (fr[i]) s = s ^ fr[i];
         fr.push_back(s);
`endif
      end
      foreach (fr[i]) begin
         send_byte(fr[i]);
         if (i != fr.size() - 1) tick($urandom_range(0, max_gap));
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((bus_if.busy || bus_if.tx_busy) && n < 5000) begin
         tick(1);
         n++;
      end
      checks++;
      if (bus_if.busy) begin
         errors++;
         $display("FAIL %s_idle_wait busy=%b required 0", tag, bus_if.busy);
      end
   endtask

   // reference: a frame yields at most one access and a fixed byte response
   task automatic check_result(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                               input logic [31:0] d);
      logic [7:0] exp[$];
      int n_wr, n_rd;
      n_wr = (cmd == 8'h57) ? 1 : 0;
      n_rd = (cmd == 8'h52) ? 1 : 0;
      if (cmd == 8'h57) exp.push_back(8'h4B);
      else if (cmd == 8'h52) begin
         for (int i = 3; i >= 0; i--) exp.push_back(rd_value[8*i +: 8]);
`ifdef UART_BUS_CHECKSUM_EN
         exp.push_back(exp[0] ^ exp[1] ^ exp[2] ^ exp[3]);
`endif
      end else exp.push_back(8'h3F);

      checks++;
      if (wr_addr_q.size() != n_wr) begin
         errors++;
         $display("FAIL %s_wr_count got %0d required %0d", tag, wr_addr_q.size(), n_wr);
      end else if (n_wr == 1) begin
         checks++;
         if (wr_addr_q[0] !== a || wr_data_q[0] !== d) begin
            errors++;
            $display("FAIL %s_wr_fields got %h/%h required %h/%h", tag, wr_addr_q[0], wr_data_q[0], a, d);
         end
      end
      checks++;
      if (rd_addr_q.size() != n_rd) begin
         errors++;
         $display("FAIL %s_rd_count got %0d required %0d", tag, rd_addr_q.size(), n_rd);
      end else if (n_rd == 1) begin
         checks++;
         if (rd_addr_q[0] !== a) begin
            errors++;
            $display("FAIL %s_rd_addr got %h required %h", tag, rd_addr_q[0], a);
         end
      end
      checks++;
      if (tx_q.size() != exp.size()) begin
         errors++;
         $display("FAIL %s_tx_count got %0d required %0d", tag, tx_q.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            checks++;
            if (tx_q[i] !== exp[i]) begin
               errors++;
               $display("FAIL %s_tx_byte%0d got %h required %h", tag, i, tx_q[i], exp[i]);
            end
         end
      end
      checks++;
      if (bad_start != 0 || overlap != 0) begin
         errors++;
         $display("FAIL %s_protocol busy_starts=%0d rd_wr_overlap=%0d required 0/0", tag, bad_start, overlap);
      end
   endtask

   task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] d, input int max_gap);
      clear_obs();
      send_frame(cmd, a, d, max_gap);
      wait_idle(tag);
      check_result(tag, cmd, a, d);
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if ({bus_if.rd, bus_if.wr, bus_if.tx_start, bus_if.busy} !== 4'b0 || bus_if.addr !== 32'h0 ||
          bus_if.wdata !== 32'h0 || bus_if.tx_data !== 8'h0) begin
         errors++;
         $display("FAIL reset_values rd/wr/start/busy=%b addr=%h wdata=%h tx=%h required all 0",
                  {bus_if.rd, bus_if.wr, bus_if.tx_start, bus_if.busy}, bus_if.addr, bus_if.wdata, bus_if.tx_data);
      end
      reset = 1'b1;
      tick(2);
   endtask

   task automatic test_write();
      clear_obs();
      send_frame(8'h57, 32'h4000000C, 32'h000000A5, 0);
      checks++;
      if (bus_if.wr !== 1'b1 || bus_if.addr !== 32'h4000000C || bus_if.wdata !== 32'h000000A5) begin
         errors++;
         $display("FAIL write_latency wr=%b addr=%h wdata=%h required 1/4000000c/000000a5",
                  bus_if.wr, bus_if.addr, bus_if.wdata);
      end
      tick(1);
      checks++;
      if (bus_if.tx_start !== 1'b1 || bus_if.tx_data !== 8'h4B || bus_if.wr !== 1'b0) begin
         errors++;
         $display("FAIL write_tx_latency start=%b tx=%h wr=%b required 1/4b/0",
                  bus_if.tx_start, bus_if.tx_data, bus_if.wr);
      end
      wait_idle("write");
      check_result("write", 8'h57, 32'h4000000C, 32'h000000A5);
   endtask

   task automatic test_read();
      rd_value = 32'h0000005A;
      clear_obs();
      send_frame(8'h52, 32'h40000010, 32'h0, 0);
      checks++;
      if (bus_if.rd !== 1'b1 || bus_if.addr !== 32'h40000010) begin
         errors++;
         $display("FAIL read_latency rd=%b addr=%h required 1/40000010", bus_if.rd, bus_if.addr);
      end
      tick(1);
      checks++;
      if (bus_if.tx_start !== 1'b1 || bus_if.tx_data !== 8'h00) begin
         errors++;
         $display("FAIL read_tx_latency start=%b tx=%h required 1/00", bus_if.tx_start, bus_if.tx_data);
      end
      wait_idle("read");
      check_result("read", 8'h52, 32'h40000010, 32'h0);
   endtask

   task automatic test_unknown();
      run_frame("unknown13", 8'h13, 32'h0, 32'h0, 0);
      for (int i = 0; i < 3; i++) run_frame("unknown_rand", pick_unknown(), 32'h0, 32'h0, 0);
   endtask

   task automatic test_timeout();
      clear_obs();
      send_byte(8'h52);
      send_byte(8'h40);
      send_byte(8'h00);
      tick(TO - 5);
      checks++;
      if (bus_if.busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early busy=%b required 1", bus_if.busy);
      end
      tick(10);
      checks++;
      if (bus_if.busy !== 1'b0 || rd_addr_q.size() != 0 || tx_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_abort busy=%b rds=%0d tx=%0d required 0/0/0",
                  bus_if.busy, rd_addr_q.size(), tx_q.size());
      end
      rd_value = $urandom;
      run_frame("after_timeout", 8'h52, 32'h12345678, 32'h0, 2);
   endtask

   task automatic test_drop();
      rd_value = $urandom;
      clear_obs();
      send_frame(8'h52, 32'h00000020, 32'h0, 1);
      for (int i = 0; i < 3; i++) send_byte(8'h57);
      wait_idle("drop");
      tick(5);
      check_result("drop", 8'h52, 32'h00000020, 32'h0);
   endtask

   task automatic test_reset_midsend();
      int n = 0;
      hold_max = 4;
      rd_value = 32'hCAFEF00D;
      clear_obs();
      send_frame(8'h52, 32'h40000010, 32'h0, 0);
      while (tx_q.size() < 2 && n < 500) begin
         tick(1);
         n++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus_if.rd, bus_if.wr, bus_if.tx_start, bus_if.busy} !== 4'b0 || bus_if.addr !== 32'h0 ||
          bus_if.wdata !== 32'h0 || bus_if.tx_data !== 8'h0 || tx_q.size() != 2) begin
         errors++;
         $display("FAIL reset_midsend rd/wr/start/busy=%b addr=%h tx=%h bytes=%0d required 0/0/0/2",
                  {bus_if.rd, bus_if.wr, bus_if.tx_start, bus_if.busy}, bus_if.addr, bus_if.tx_data, tx_q.size());
      end
      tick(1);
      reset = 1'b1;
      n = 0;
      while (bus_if.tx_busy && n < 50) begin
         tick(1);
         n++;
      end
      run_frame("after_reset", 8'h57, 32'h4000000C, 32'h000000A5, 1);
   endtask

   task automatic test_random();
      logic [7:0] cmd;
      logic [31:0] a, d, last_w;
      bit have_w;
      int k;
      have_w = 1'b0;
      last_w = 32'h0;
      for (int i = 0; i < 24; i++) begin
         k = $urandom_range(0, 5);
         hold_max = $urandom_range(1, 6);
         a = $urandom;
         d = $urandom;
         rd_value = $urandom;
         cmd = (k < 3) ? 8'h57 : (k < 5) ? 8'h52 : pick_unknown();
         run_frame("random", cmd, a, d, $urandom_range(0, 5));
         if (cmd == 8'h57) begin
            have_w = 1'b1;
            last_w = d;
         end
         if (cmd == 8'h52 || cmd == 8'h57) begin
            checks++;
            if (bus_if.addr !== a) begin
               errors++;
               $display("FAIL random_addr_hold got %h required %h", bus_if.addr, a);
            end
         end
         if (have_w) begin
            checks++;
            if (bus_if.wdata !== last_w) begin
               errors++;
               $display("FAIL random_wdata_hold got %h required %h", bus_if.wdata, last_w);
            end
         end
      end
   endtask

`ifdef UART_BUS_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] fr[$];
      for (int pass = 0; pass < 2; pass++) begin
         fr = {8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
         fr.push_back(pass == 0 ? 8'h00 : 8'h56);
         clear_obs();
         foreach (fr[i]) send_byte(fr[i]);
         wait_idle("checksum");
         checks++;
         if (wr_addr_q.size() != pass || tx_q.size() != 1) begin
            errors++;
            $display("FAIL checksum_counts pass=%0d wrs=%0d tx=%0d required %0d/1",
                     pass, wr_addr_q.size(), tx_q.size(), pass);
         end else begin
            checks++;
            if (tx_q[0] !== (pass == 0 ? 8'h21 : 8'h4B)) begin
               errors++;
               $display("FAIL checksum_resp pass=%0d got %h required %h", pass, tx_q[0],
                        pass == 0 ? 8'h21 : 8'h4B);
            end
         end
      end
   endtask
`endif

   initial begin
      bus_if.rx_data  = 8'h00;
      bus_if.rx_valid = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_timeout();
      test_drop();
      test_reset_midsend();
      test_random();
`ifdef UART_BUS_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
